// File: rtl/dla_pkg.sv
// Shared types and default datapath constants for the DLA elastic pipeline.
package dla_pkg;

    localparam int unsigned DLA_ACC_W = 20;
    localparam int unsigned DLA_CH    = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/dla_skid_stage.sv
// One skid-buffered pipeline stage: main register feeds the output, skid register
// catches the beat accepted in the cycle the downstream stalls, ready is a state decode.
module dla_skid_stage
    import dla_pkg::*;
#(
    parameter int unsigned W  = DLA_ACC_W,
    parameter int unsigned CH = DLA_CH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data [CH-1:0],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data [CH-1:0]
);

    skid_state_e  state;
    skid_state_e  state_next;
    logic [W-1:0] main_reg [CH-1:0];
    logic [W-1:0] skid_reg [CH-1:0];
    logic         acc;
    logic         take;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_reg;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        acc            = in_valid && (state != FULL);
        take           = (state != EMPTY) && out_ready;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_next = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (acc && !take) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (take && !acc) begin
                    state_next = EMPTY;
                end else if (acc && take) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (take) begin
                    state_next     = BUSY;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush only drops state; the data registers keep their stale contents.
        if (clear) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
            for (int unsigned c = 0; c < CH; c++) begin
                main_reg[c] <= '0;
                skid_reg[c] <= '0;
            end
        end else begin
            state <= state_next;
            if (load_main) begin
                main_reg <= in_data;
            end else if (main_from_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/dla_elastic_pipe.sv
// Multi-channel elastic pipeline: DEPTH chained skid stages with registered ready,
// synchronous flush gating and a beat occupancy counter.
module dla_elastic_pipe
    import dla_pkg::*;
#(
    parameter int unsigned W     = DLA_ACC_W,
    parameter int unsigned CH    = DLA_CH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OCC_W = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data [CH-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data [CH-1:0],
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0] link_valid;
    logic [DEPTH:0] link_ready;
    logic [W-1:0]   link_data [DEPTH:0][CH-1:0];
    logic           in_fire;
    logic           out_fire;

    // Flush masks both ends so nothing crosses the boundary in the clearing cycle.
    assign link_valid[0]     = in_valid && !flush;
    assign link_ready[DEPTH] = out_ready && !flush;
    assign link_data[0]      = in_data;

    assign in_ready  = link_ready[0] && !flush;
    assign out_valid = link_valid[DEPTH] && !flush;
    assign out_data  = link_data[DEPTH];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dla_skid_stage #(
            .W  (W),
            .CH (CH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .in_valid  (link_valid[k]),
            .in_ready  (link_ready[k]),
            .in_data   (link_data[k]),
            .out_valid (link_valid[k+1]),
            .out_ready (link_ready[k+1]),
            .out_data  (link_data[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_dla_elastic_pipe.sv
// Bench for dla_elastic_pipe: table-driven streaming, directed corner sequences
// and a randomized run against a queue-based reference.
module tb_dla_elastic_pipe;

    localparam int unsigned W     = 20;
    localparam int unsigned CH    = 3;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

    typedef logic [CH-1:0][W-1:0] beat_t;

    typedef struct {
        logic        v;
        logic        r;
        int unsigned n;
        logic        exp_ir;
        logic        exp_ov;
        int unsigned exp_n;
        int unsigned exp_occ;
    } vec_t;

    typedef struct {
        beat_t       d;
        int unsigned acc;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     in_data [CH-1:0];
    logic [W-1:0]     out_data [CH-1:0];
    logic [OCC_W-1:0] occupancy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        s_in_ready, s_out_valid, in_fire, out_fire;
    int unsigned s_occ;
    beat_t       s_out;

    dla_elastic_pipe #(
        .W     (W),
        .CH    (CH),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t beat(input int unsigned n);
        beat_t b;
        for (int c = 0; c < CH; c++) b[c] = W'(n + c * 'h100);
        return b;
    endfunction

    function automatic beat_t splat(input int unsigned v);
        beat_t b;
        for (int c = 0; c < CH; c++) b[c] = W'(v);
        return b;
    endfunction

    task automatic set_in(input beat_t b);
        for (int c = 0; c < CH; c++) in_data[c] = b[c];
    endtask

    function automatic beat_t cur_in();
        beat_t b;
        for (int c = 0; c < CH; c++) b[c] = in_data[c];
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are already applied; sample settled outputs, then cross one clock edge.
    task automatic tick();
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_occ       = occupancy;
        for (int c = 0; c < CH; c++) s_out[c] = out_data[c];
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic latency_probe(input string name, input beat_t b);
        int unsigned lat;
        logic        seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(b);
        tick();
        chk({name, "_accept"}, in_fire, 1'b1);
        in_valid = 1'b0;
        set_in(splat(0));
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            lat++;
            if (out_fire) seen = 1'b1;
        end
        chk({name, "_seen"}, seen, 1'b1);
        chk({name, "_latency"}, lat, DEPTH);
        chk({name, "_data"}, s_out, b);
    endtask

    vec_t tbl [11];

    initial begin
        //            v     r     n  ir    ov    en occ
        tbl[0]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 2, 1'b1, 1'b0, 0, 1};
        tbl[2]  = '{1'b1, 1'b1, 3, 1'b1, 1'b1, 1, 2};
        tbl[3]  = '{1'b1, 1'b1, 4, 1'b1, 1'b1, 2, 2};
        tbl[4]  = '{1'b1, 1'b1, 5, 1'b1, 1'b1, 3, 2};
        tbl[5]  = '{1'b1, 1'b1, 6, 1'b1, 1'b1, 4, 2};
        tbl[6]  = '{1'b1, 1'b1, 7, 1'b1, 1'b1, 5, 2};
        tbl[7]  = '{1'b1, 1'b1, 8, 1'b1, 1'b1, 6, 2};
        tbl[8]  = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 7, 2};
        tbl[9]  = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 8, 1};
        tbl[10] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 0};

        // Reset with junk on the input.
        rst = 1'b0;
        in_valid = 1'b1;
        set_in(splat('hABCDE));
        tick();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("reset_in_ready", s_in_ready, 1'b1);
        chk("reset_out_valid", s_out_valid, 1'b0);
        chk("reset_occ", s_occ, 0);
        chk("reset_data", s_out, splat(0));

        // Back-to-back streaming.
        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].v;
            out_ready = tbl[i].r;
            set_in(beat(tbl[i].n));
            tick();
            chk($sformatf("stream%0d_in_ready", i), s_in_ready, tbl[i].exp_ir);
            chk($sformatf("stream%0d_out_valid", i), s_out_valid, tbl[i].exp_ov);
            chk($sformatf("stream%0d_occ", i), s_occ, tbl[i].exp_occ);
            if (tbl[i].exp_ov) chk($sformatf("stream%0d_data", i), s_out, beat(tbl[i].exp_n));
        end

        // Backpressure: fill until ready drops, then release.
        begin
            int unsigned seed, next_exp, rec_cyc;
            logic        dropped, recovered, first_out;
            seed = 'h20;
            next_exp = 'h20;
            dropped = 1'b0;
            out_ready = 1'b0;
            in_valid = 1'b1;
            for (int i = 0; i < 20 && !dropped; i++) begin
                set_in(beat(seed));
                tick();
                if (in_fire) seed++;
                if (!s_in_ready) dropped = 1'b1;
            end
            chk("bp_ready_dropped", dropped, 1'b1);
            chk("bp_accepted", seed - 'h20, 2 * DEPTH);
            chk("bp_occ_full", s_occ, 2 * DEPTH);
            out_ready = 1'b1;
            recovered = 1'b0;
            first_out = 1'b0;
            rec_cyc = 0;
            for (int i = 0; i < 14; i++) begin
                set_in(beat(seed));
                tick();
                if (in_fire) seed++;
                chk($sformatf("bp%0d_out_valid", i), s_out_valid, 1'b1);
                if (out_fire) begin
                    chk($sformatf("bp%0d_data", i), s_out, beat(next_exp));
                    next_exp++;
                    first_out = 1'b1;
                end
                if (recovered) chk($sformatf("bp%0d_no_gap", i), s_in_ready, 1'b1);
                else if (s_in_ready) recovered = 1'b1;
                else if (first_out) rec_cyc++;
            end
            chk("bp_recovered", recovered, 1'b1);
            chk("bp_recovery_bound", rec_cyc <= DEPTH, 1'b1);
            chk("bp_new_beats_out", next_exp > 'h20 + 2 * DEPTH, 1'b1);
            in_valid = 1'b0;
            for (int i = 0; i < 6; i++) tick();
            tick();
            chk("bp_drained_occ", s_occ, 0);
        end

        // Flush with three beats held.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(beat('h40 + i));
            tick();
        end
        flush = 1'b1;
        set_in(splat('h777));
        tick();
        chk("flush_occ_before", s_occ, 3);
        chk("flush_in_ready", s_in_ready, 1'b0);
        chk("flush_out_valid", s_out_valid, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_occ_after", s_occ, 0);
        chk("flush_out_valid_after", s_out_valid, 1'b0);
        latency_probe("flush_probe", beat('h50));

        // Reset mid-stream with the pipe full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(beat('h60 + i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("mrst_occ_before", s_occ, 4);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mrst_in_ready", s_in_ready, 1'b1);
        chk("mrst_out_valid", s_out_valid, 1'b0);
        chk("mrst_occ", s_occ, 0);
        chk("mrst_data", s_out, splat(0));
        latency_probe("mrst_probe", splat('h12345));

        // Randomized traffic against an ordered queue of accepted beats.
        begin
            ent_t        q [$];
            int unsigned last_pop, since;
            beat_t       prev_out;
            logic        prev_stall;
            last_pop = 0;
            prev_stall = 1'b0;
            prev_out = '0;
            for (int unsigned c = 0; c < 2000; c++) begin
                in_valid  = 1'($urandom % 2);
                out_ready = 1'($urandom % 2);
                for (int ch = 0; ch < CH; ch++) in_data[ch] = W'($urandom);
                tick();
                chk("rnd_occ", s_occ, q.size());
                if (s_out_valid) begin
                    if (q.size() == 0) chk("rnd_spurious_valid", s_out_valid, 1'b0);
                    else chk("rnd_data", s_out, q[0].d);
                end
                if (q.size() != 0) begin
                    since = (q[0].acc > last_pop) ? q[0].acc : last_pop;
                    if (c >= since + DEPTH) chk("rnd_valid_due", s_out_valid, 1'b1);
                end
                if (q.size() == 2 * DEPTH) chk("rnd_full_ready", s_in_ready, 1'b0);
                if (prev_stall) begin
                    chk("rnd_stall_valid", s_out_valid, 1'b1);
                    chk("rnd_stall_data", s_out, prev_out);
                end
                prev_stall = s_out_valid && !out_ready;
                prev_out = s_out;
                if (out_fire && q.size() != 0) begin
                    void'(q.pop_front());
                    last_pop = c;
                end
                if (in_fire) q.push_back('{d: cur_in(), acc: c});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dla_elastic_pipe.md
# dla_elastic_pipe

Parametrised, multi-channel elastic pipeline register for the DLA datapath, placed between arithmetic stages such as adder trees and accumulators. It is the successor to the fixed 3×20-bit stall-register stages. It replaces the global stall with a per-stage valid/ready handshake, uses skid buffering for full throughput with registered ready, and adds a synchronous flush and an occupancy count. Channel count, data width and stage depth are configurable.

## Interface
- `W`, default 20: bits per channel.
- `CH`, default 3: number of channels, transferred together as one beat.
- `DEPTH`, default 2: number of skid stages. Legal values are DEPTH ≥ 1.
- `OCC_W`, default `$clog2(2*DEPTH+1)`: width of the occupancy output.
- `clk` in, 1: clock.
- `rst` in, 1: reset. Synchronous, active-low.
- `flush` in, 1: synchronous pipeline clear.
- `in_valid` in, 1: upstream beat valid.
- `in_ready` out, 1: stage 0 can accept a beat.
- `in_data` in, `[W-1:0] x [CH-1:0]` (unpacked array of channels): input beat.
- `out_valid` out, 1: last stage holds a beat.
- `out_ready` in, 1: downstream accepts the beat.
- `out_data` out, `[W-1:0] x [CH-1:0]`: output beat.
- `occupancy` out, OCC_W: number of beats held, range 0..2*DEPTH.

## Operation
- A transfer occurs on an input when valid & ready are both high at a clk edge. Beats move through the pipe intact, with all channels together and in order. There is no loss and no duplication.
- Each stage has a main register, a skid register, and a state in {EMPTY, BUSY, FULL}.
  - The stage's out_valid is `state != EMPTY`. Its data output comes from the main register.
  - The stage's in_ready is `state != FULL`, so it is a direct decode of the state register.
- Stage transitions ("acc" = upstream transfer into the stage, "take" = downstream transfer out of the stage):
  - EMPTY, acc: go to BUSY; main ← in.
  - BUSY, acc and no take: go to FULL; skid ← in.
  - BUSY, take and no acc: go to EMPTY.
  - BUSY, acc and take: stay BUSY; main ← in.
  - BUSY, neither: hold.
  - FULL, take: go to BUSY; main ← skid.
  - FULL, no take: hold. No acc is possible because in_ready is 0.
- Stages are chained: stage k's out_valid/data drive stage k+1's input, and stage k+1's in_ready drives stage k's take.
  - Top-level in_valid/in_data/in_ready connect to stage 0.
  - Top-level out_valid/out_data/out_ready connect to stage DEPTH-1.
- Occupancy rules:
  - Increments by 1 on an input transfer and decrements by 1 on an output transfer.
  - Holds when both or neither transfer happens.
  - Saturation is never needed because capacity is exactly 2*DEPTH.
- Flush, when high at an edge:
  - All stages go to EMPTY and occupancy goes to 0. Data registers are not cleared.
  - During the flush cycle, the top-level in_ready and out_valid are forced to 0, so no transfer happens on either side in that cycle.
- Reset, when rst is low at an edge:
  - All stages go to EMPTY and every main and skid register clears to 0. Occupancy goes to 0.
  - Reset has priority over flush. Inputs are ignored while rst is low.
- Data is carried verbatim. This block performs no arithmetic and no width change.

## Timing
- Reset values: out_valid=0, out_data all channels 0, in_ready=1, occupancy=0.
- Latency is DEPTH cycles from an input transfer to out_valid, when downstream has been ready.
- Throughput is 1 beat per cycle under continuous out_ready=1.
- in_ready depends only on flops plus the flush gate. There is no combinational path from out_ready to in_ready.
- Under backpressure (out_ready=0), exactly 2*DEPTH beats are accepted, then in_ready falls.
  - in_ready reasserts the cycle after the first output transfer, once the resulting bubble has propagated back through the registered ready. This takes at most DEPTH cycles.
- out_data is stable while out_valid=1 and out_ready=0.
- If reset or flush is asserted mid-stream, in-flight beats are discarded. The first beat accepted afterwards appears DEPTH cycles after its acceptance.

## Structure
- Sub-module `dla_skid_stage`: a single stage parametrised by W and CH. It is instantiated DEPTH times in a generate loop.
- Shared package `dla_pkg`:
  - Stage state enum `skid_state_e` {EMPTY, BUSY, FULL}.
  - Default datapath constants: `DLA_ACC_W=20`, `DLA_CH=3`.
- Occupancy counter and flush gating live in the top level.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=0xABCDE. Require out_valid=0, out_data all 0, in_ready=1 and occupancy=0 after release.
- Streaming (DEPTH=2, CH=3, W=20, out_ready=1): feed beats {n, n+0x100, n+0x200} for n=1..8 back-to-back.
  - The first output appears 2 cycles after the first input transfer.
  - Outputs then arrive 8 consecutive cycles in order; occupancy stays at 2 in steady state.
- Backpressure: set out_ready=0 and hold in_valid=1.
  - Require exactly 4 accepted beats, then in_ready=0 and occupancy=4.
  - Then set out_ready=1: the 4 beats emerge in order, followed by new beats, with no gap once in_ready recovers.
- Random: in_valid and out_ready each toggle randomly at 50% for 2000 cycles against a scoreboard.
  - Require no loss, no duplication and correct order.
  - Require occupancy to equal the scoreboard depth every cycle.
  - Require out_data to stay stable while stalled.
- Flush: with occupancy=3, assert flush for 1 cycle while in_valid=1.
  - Next cycle: occupancy=0, out_valid=0, and the beat presented in the flush cycle never appears.
- Reset mid-stream: pull rst low for 1 cycle with occupancy=4.
  - Afterwards all outputs are at their reset values, and a new beat 0x12345 emerges 2 cycles after acceptance.
